// File: rtl/pc_ring_pkg.sv
// Shared definitions for the performance-counter ring: field widths, pc-type
// encodings and the packed packet header carried between ring nodes.
package pc_ring_pkg;

   localparam int unsigned MODULE_ID_W = 16;
   localparam int unsigned PORT_ID_W   = 8;
   localparam int unsigned PC_TYPE_W   = 4;

   typedef enum logic [PC_TYPE_W-1:0] {
      PC_XFER   = 4'd0,
      PC_STALL  = 4'd1,
      PC_IDLE   = 4'd2,
      PC_CYCLES = 4'd3,
      PC_CLEAR  = 4'd4,
      PC_ERR    = 4'hF
   } pcType_e;

   // pcValue is carried alongside the header because its width is a node parameter.
   typedef struct packed {
      logic                   request;
      logic [MODULE_ID_W-1:0] moduleId;
      logic [PORT_ID_W-1:0]   portId;
      logic [PC_TYPE_W-1:0]   pcType;
   } ringHdr_t;

endpackage

// File: rtl/pc_monitor_node_if.sv
// Monitor node bundle: snooped stream handshakes plus the pcIn/pcOut ring hop.
interface pc_monitor_node_if #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned PCV_W     = 16
) ();
   import pc_ring_pkg::*;

   logic                   count_en;
   logic [NUM_PORTS-1:0]   mon_valid;
   logic [NUM_PORTS-1:0]   mon_ready;

   logic                   pc_in_valid;
   logic                   pc_in_request;
   logic [MODULE_ID_W-1:0] pc_in_module_id;
   logic [PORT_ID_W-1:0]   pc_in_port_id;
   logic [PCV_W-1:0]       pc_in_pc_value;
   logic [PC_TYPE_W-1:0]   pc_in_pc_type;

   logic                   pc_out_valid;
   logic                   pc_out_request;
   logic [MODULE_ID_W-1:0] pc_out_module_id;
   logic [PORT_ID_W-1:0]   pc_out_port_id;
   logic [PCV_W-1:0]       pc_out_pc_value;
   logic [PC_TYPE_W-1:0]   pc_out_pc_type;

   modport master (
      output count_en, mon_valid, mon_ready,
      output pc_in_valid, pc_in_request, pc_in_module_id, pc_in_port_id,
             pc_in_pc_value, pc_in_pc_type,
      input  pc_out_valid, pc_out_request, pc_out_module_id, pc_out_port_id,
             pc_out_pc_value, pc_out_pc_type
   );

   modport slave (
      input  count_en, mon_valid, mon_ready,
      input  pc_in_valid, pc_in_request, pc_in_module_id, pc_in_port_id,
             pc_in_pc_value, pc_in_pc_type,
      output pc_out_valid, pc_out_request, pc_out_module_id, pc_out_port_id,
             pc_out_pc_value, pc_out_pc_type
   );

endinterface

// File: rtl/pc_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; clear wins over increment.
module pc_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pc_monitor_node.sv
// Performance-counter ring node: counts per-port XFER/STALL/IDLE events plus a
// shared cycle count, answers reads/clears for MODULE_ID and forwards the rest.
module pc_monitor_node
   import pc_ring_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter logic [15:0] MODULE_ID = 16'h0001,
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned PCV_W     = 16
) (
   input logic               clk,
   input logic               reset,
   pc_monitor_node_if.slave  bus
);

   localparam int unsigned NUM_CNT = 3 * NUM_PORTS + 1;
   localparam int unsigned SEL_W   = $clog2(NUM_CNT);
   localparam int unsigned CYC_IDX = NUM_CNT - 1;

   logic [NUM_CNT-1:0] incVec;
   logic [CNT_W-1:0]   cntArr [NUM_CNT];
   logic               isMatch;
   logic               portLegal;
   logic               clrAll;
   logic [SEL_W-1:0]   readIdx;
   logic [CNT_W-1:0]   selCnt;
   logic [PCV_W-1:0]   selValue;
   ringHdr_t           inHdr;
   ringHdr_t           nxtHdr;
   logic [PCV_W-1:0]   nxtValue;
   logic               outValid;
   ringHdr_t           outHdr;
   logic [PCV_W-1:0]   outValue;

   // Counter layout: index 3*port+type for per-port events, last slot is the cycle count.
   for (genvar p = 0; p < NUM_PORTS; p++) begin : gPortEv
      assign incVec[3*p]   =  bus.mon_valid[p] &  bus.mon_ready[p];
      assign incVec[3*p+1] =  bus.mon_valid[p] & ~bus.mon_ready[p];
      assign incVec[3*p+2] = ~bus.mon_valid[p] &  bus.mon_ready[p];
   end
   assign incVec[CYC_IDX] = 1'b1;

   for (genvar c = 0; c < NUM_CNT; c++) begin : gCnt
      pc_sat_counter #(.CNT_W(CNT_W)) uCnt (
         .clk   (clk),
         .reset (reset),
         .en    (bus.count_en),
         .inc   (incVec[c]),
         .clr   (clrAll),
         .count (cntArr[c])
      );
   end

   assign inHdr = {bus.pc_in_request, bus.pc_in_module_id,
                   bus.pc_in_port_id, bus.pc_in_pc_type};

   assign isMatch   = bus.pc_in_valid & bus.pc_in_request &
                      (bus.pc_in_module_id == MODULE_ID);
   assign portLegal = (32'(bus.pc_in_port_id) < NUM_PORTS);
   assign clrAll    = isMatch & (bus.pc_in_pc_type == PC_CLEAR);

   // Only in-range indices are ever formed; anything else falls back to slot 0 and is discarded.
   always_comb begin
      readIdx = '0;
      if (bus.pc_in_pc_type == PC_CYCLES) begin
         readIdx = SEL_W'(CYC_IDX);
      end else if (portLegal && (bus.pc_in_pc_type < PC_CYCLES)) begin
         readIdx = SEL_W'(32'(bus.pc_in_port_id) * 32'd3 + 32'(bus.pc_in_pc_type));
      end
   end

   assign selCnt = cntArr[readIdx];

   if (CNT_W > PCV_W) begin : gClip
      assign selValue = (|selCnt[CNT_W-1:PCV_W]) ? '1 : selCnt[PCV_W-1:0];
   end else begin : gNoClip
      assign selValue = PCV_W'(selCnt);
   end

   always_comb begin
      nxtHdr   = inHdr;
      nxtValue = bus.pc_in_pc_value;
      if (isMatch) begin
         nxtHdr.request = 1'b0;
         case (bus.pc_in_pc_type)
            PC_XFER, PC_STALL, PC_IDLE: begin
               if (portLegal) begin
                  nxtValue = selValue;
               end else begin
                  nxtHdr.pcType = PC_ERR;
                  nxtValue      = '0;
               end
            end
            PC_CYCLES: nxtValue = selValue;
            PC_CLEAR:  nxtValue = '0;
            default: begin
               nxtHdr.pcType = PC_ERR;
               nxtValue      = '0;
            end
         endcase
      end
   end

   // Ring hop register: fields only load on a valid packet, otherwise they hold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         outValid <= 1'b0;
         outHdr   <= '0;
         outValue <= '0;
      end else begin
         outValid <= bus.pc_in_valid;
         if (bus.pc_in_valid) begin
            outHdr   <= nxtHdr;
            outValue <= nxtValue;
         end
      end
   end

   assign bus.pc_out_valid     = outValid;
   assign bus.pc_out_request   = outHdr.request;
   assign bus.pc_out_module_id = outHdr.moduleId;
   assign bus.pc_out_port_id   = outHdr.portId;
   assign bus.pc_out_pc_value  = outValue;
   assign bus.pc_out_pc_type   = outHdr.pcType;

endmodule

// File: tb/tb_pc_monitor_node.sv
// Directed bench for pc_monitor_node: every cycle queues the expected ring output
// and compares it against the DUT one cycle later.
module tb_pc_monitor_node;

   localparam int unsigned NP  = 4;
   localparam logic [15:0] MOD = 16'h0001;

   typedef struct packed {
      logic        v;
      logic        req;
      logic [15:0] mid;
      logic [7:0]  pid;
      logic [15:0] val;
      logic [3:0]  typ;
   } obs_t;

   typedef struct {
      obs_t  pkt;
      string tag;
   } expEnt_t;

   logic        clk;
   logic        reset;
   expEnt_t     expQ [$];
   obs_t        lastExp;
   int unsigned cycEn;
   logic        clrNow;
   int          checks;
   int          errors;

   pc_monitor_node_if #(.NUM_PORTS(NP), .PCV_W(16)) bus ();

   pc_monitor_node #(
      .NUM_PORTS (NP),
      .MODULE_ID (MOD),
      .CNT_W     (16),
      .PCV_W     (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pushExp(input obs_t e, input string tag);
      expEnt_t ent;
      ent.pkt = e;
      ent.tag = tag;
      expQ.push_back(ent);
      lastExp = e;
   endtask

   // Advance one cycle, keep the cycle-count model in step, then check the output.
   task automatic step();
      expEnt_t ent;
      obs_t    got;
      if (clrNow) cycEn = 0;
      else if (bus.count_en && reset && cycEn < 32'd65535) cycEn++;
      clrNow = 1'b0;
      @(negedge clk);
      got = {bus.pc_out_valid, bus.pc_out_request, bus.pc_out_module_id,
             bus.pc_out_port_id, bus.pc_out_pc_value, bus.pc_out_pc_type};
      ent = expQ.pop_front();
      checks++;
      assert (got === ent.pkt)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", ent.tag, got, ent.pkt);
      end
   endtask

   task automatic idle(input int n, input string tag);
      obs_t e;
      for (int i = 0; i < n; i++) begin
         bus.pc_in_valid = 1'b0;
         e   = lastExp;
         e.v = 1'b0;
         pushExp(e, tag);
         step();
      end
   endtask

   task automatic send(input logic req, input logic [15:0] mid, input logic [7:0] pid,
                       input logic [15:0] val, input logic [3:0] typ,
                       input obs_t e, input string tag);
      bus.pc_in_valid     = 1'b1;
      bus.pc_in_request   = req;
      bus.pc_in_module_id = mid;
      bus.pc_in_port_id   = pid;
      bus.pc_in_pc_value  = val;
      bus.pc_in_pc_type   = typ;
      pushExp(e, tag);
      step();
   endtask

   task automatic fwd(input logic req, input logic [15:0] mid, input logic [7:0] pid,
                      input logic [15:0] val, input logic [3:0] typ, input string tag);
      send(req, mid, pid, val, typ, {1'b1, req, mid, pid, val, typ}, tag);
   endtask

   task automatic rd(input logic [7:0] pid, input logic [3:0] typ,
                     input logic [15:0] expVal, input logic [3:0] expTyp, input string tag);
      send(1'b1, MOD, pid, 16'h5A5A, typ, {1'b1, 1'b0, MOD, pid, expVal, expTyp}, tag);
   endtask

   task automatic mon(input logic en, input logic [NP-1:0] v, input logic [NP-1:0] r);
      bus.count_en  = en;
      bus.mon_valid = v;
      bus.mon_ready = r;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cycEn   = 0;
      clrNow  = 1'b0;
      lastExp = '0;

      // Reset with a live packet on the ring: output must stay idle and zero.
      reset = 1'b0;
      mon(1'b0, '0, '0);
      bus.pc_in_valid     = 1'b1;
      bus.pc_in_request   = 1'b1;
      bus.pc_in_module_id = MOD;
      bus.pc_in_port_id   = 8'd2;
      bus.pc_in_pc_value  = 16'hBEEF;
      bus.pc_in_pc_type   = 4'd0;
      for (int i = 0; i < 3; i++) begin
         pushExp('0, "reset");
         step();
      end
      reset = 1'b1;
      cycEn = 0;
      idle(1, "post_reset");

      rd(8'd2, 4'd0, 16'd0, 4'd0, "rst_xfer");
      rd(8'd2, 4'd1, 16'd0, 4'd1, "rst_stall");
      rd(8'd3, 4'd2, 16'd0, 4'd2, "rst_idle");
      rd(8'd0, 4'd3, 16'(cycEn), 4'd3, "rst_cycles");

      // Port 2: 5 XFER, 3 STALL, 2 IDLE.
      mon(1'b1, 4'b0100, 4'b0100); idle(5, "traffic");
      mon(1'b1, 4'b0100, 4'b0000); idle(3, "traffic");
      mon(1'b1, 4'b0000, 4'b0100); idle(2, "traffic");
      mon(1'b1, 4'b0000, 4'b0000);
      rd(8'd2, 4'd0, 16'd5, 4'd0, "p2_xfer");
      rd(8'd2, 4'd1, 16'd3, 4'd1, "p2_stall");
      rd(8'd2, 4'd2, 16'd2, 4'd2, "p2_idle");
      rd(8'd1, 4'd0, 16'd0, 4'd0, "p1_xfer_untouched");
      rd(8'd255, 4'd3, 16'(cycEn), 4'd3, "cycles_any_port");

      // Traffic not addressed to this node, or not a request, passes unchanged.
      fwd(1'b1, 16'h0007, 8'd5, 16'h1234, 4'd2, "fwd_other_mod");
      fwd(1'b0, MOD, 8'd2, 16'h4321, 4'd0, "fwd_answered");
      idle(2, "hold");

      // Illegal port / type.
      rd(8'(NP), 4'd0, 16'd0, 4'hF, "err_port");
      rd(8'd0, 4'd6, 16'd0, 4'hF, "err_type6");
      rd(8'd1, 4'd15, 16'd0, 4'hF, "err_type15");

      // count_en low: traffic must not count.
      mon(1'b0, 4'b0100, 4'b0100); idle(10, "count_en_off");
      mon(1'b1, 4'b0000, 4'b0000);
      rd(8'd2, 4'd0, 16'd5, 4'd0, "hold_xfer");
      rd(8'd2, 4'd1, 16'd3, 4'd1, "hold_stall");
      rd(8'd0, 4'd3, 16'(cycEn), 4'd3, "hold_cycles");

      // Clear in the same cycle as a port-1 XFER: that event is lost.
      mon(1'b1, 4'b0010, 4'b0010); idle(2, "p1_traffic");
      clrNow = 1'b1;
      send(1'b1, MOD, 8'd0, 16'hABCD, 4'd4, {1'b1, 1'b0, MOD, 8'd0, 16'd0, 4'd4}, "clear");
      mon(1'b1, 4'b0000, 4'b0000);
      rd(8'd1, 4'd0, 16'd0, 4'd0, "clr_p1_xfer");
      rd(8'd2, 4'd0, 16'd0, 4'd0, "clr_p2_xfer");
      rd(8'd2, 4'd1, 16'd0, 4'd1, "clr_p2_stall");
      rd(8'd0, 4'd3, 16'(cycEn), 4'd3, "clr_cycles");

      // Saturation: 70000 XFERs on port 0 must stick at 16'hFFFF.
      mon(1'b1, 4'b0001, 4'b0001); idle(70000, "sat_traffic");
      mon(1'b1, 4'b0000, 4'b0000);
      rd(8'd0, 4'd0, 16'hFFFF, 4'd0, "sat_xfer");
      rd(8'd0, 4'd1, 16'd0, 4'd1, "sat_stall");
      rd(8'd0, 4'd3, 16'(cycEn), 4'd3, "sat_cycles");
      idle(2, "final_hold");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
